mode_ctrl: RTL and testbench

MODE_CTRL -- requirements
Module: mode_ctrl

---
 rtl/mode_ctrl_if.sv | 21 ++
 rtl/mode_ctrl.sv | 148 ++++++++++++++
 tb/tb_mode_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mode_ctrl_if.sv
// Button inputs and mode/pulse outputs of the mode controller.
// master: button source (panel/bench); slave: mode_ctrl.
interface mode_ctrl_if;
    logic       mode_btn;
    logic       set_btn;
    logic       inc_btn;
    logic [1:0] mode1;
    logic [1:0] mode2;
    logic       increase;
    logic       set;

    modport master (
        output mode_btn, set_btn, inc_btn,
        input  mode1, mode2, increase, set
    );

    modport slave (
        input  mode_btn, set_btn, inc_btn,
        output mode1, mode2, increase, set
    );
endinterface

// File: rtl/mode_ctrl.sv
// Clock mode controller: steps major/sub modes from three buttons, issues
// increment pulses with hold-to-repeat, and drops edit sub-modes after an
// idle timeout. All outputs are registered.
module mode_ctrl #(
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100,
    parameter int unsigned IDLE_TIMEOUT = 10000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    mode_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        M1_TIME  = 2'd0,
        M1_DATE  = 2'd1,
        M1_TIMER = 2'd2,
        M1_ALARM = 2'd3
    } mode1_t;

    // REP_DELAY waits for the first repeat, REP_RATE for each later one.
    typedef enum logic [1:0] {
        REP_OFF   = 2'd0,
        REP_DELAY = 2'd1,
        REP_RATE  = 2'd2
    } rep_t;

    localparam logic [CNT_W-1:0] C_DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] C_RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] C_IDLE_LAST  = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

    logic             r_mode_d, r_set_d, r_inc_d;
    mode1_t           r_mode1;
    logic [1:0]       r_mode2;
    logic             r_increase, r_set;
    rep_t             r_rep_st;
    logic [CNT_W-1:0] r_rep_cnt, r_idle_cnt;

    logic             w_mode_p, w_set_p, w_inc_p;
    logic             w_edit, w_timeout, w_rep_hit;
    mode1_t           w_mode1;
    logic [1:0]       w_mode2;
    logic             w_increase, w_set;
    rep_t             w_rep_st;
    logic [CNT_W-1:0] w_rep_cnt, w_idle_cnt, w_rep_inc, w_idle_inc;

    // Press detection with mode > set > inc priority; losers are dropped.
    always_comb begin
        w_mode_p   = bus.mode_btn & ~r_mode_d;
        w_set_p    = bus.set_btn  & ~r_set_d & ~w_mode_p;
        w_inc_p    = bus.inc_btn  & ~r_inc_d & ~w_mode_p & ~w_set_p;
        w_edit     = (r_mode1 != M1_TIMER) && (r_mode2 != 2'd0);
        w_timeout  = w_edit && (r_idle_cnt == C_IDLE_LAST);
        w_rep_inc  = (r_rep_cnt  == '1) ? r_rep_cnt  : r_rep_cnt  + C_ONE;
        w_idle_inc = (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + C_ONE;
        w_rep_hit  = ((r_rep_st == REP_DELAY) && (r_rep_cnt == C_DELAY_LAST)) ||
                     ((r_rep_st == REP_RATE)  && (r_rep_cnt == C_RATE_LAST));
    end

    // Next mode, pulse and counter values. Counters and repeat state fall
    // back to zero/off unless a branch keeps them, which covers release,
    // mode changes and leaving edit state in one place.
    always_comb begin
        w_mode1    = r_mode1;
        w_mode2    = r_mode2;
        w_increase = 1'b0;
        w_set      = 1'b0;
        w_rep_st   = REP_OFF;
        w_rep_cnt  = '0;
        w_idle_cnt = '0;

        if (w_mode_p) begin
            case (r_mode1)
                M1_TIME:  w_mode1 = M1_DATE;
                M1_DATE:  w_mode1 = M1_TIMER;
                M1_TIMER: w_mode1 = M1_ALARM;
                default:  w_mode1 = M1_TIME;
            endcase
            w_mode2 = 2'd0;
        end else if (w_set_p) begin
            w_set = 1'b1;
            if (r_mode1 == M1_TIMER) begin
                w_mode2 = (r_mode2 == 2'd0) ? 2'd1 : 2'd0;
            end else begin
                case (r_mode2)
                    2'd0:    w_mode2 = 2'd1;
                    2'd1:    w_mode2 = 2'd2;
                    default: w_mode2 = 2'd0;
                endcase
            end
        end else if (w_inc_p) begin
            if (w_edit) begin
                w_increase = 1'b1;
                w_rep_st   = REP_DELAY;
            end
        end else if (w_timeout) begin
            w_mode2 = 2'd0;
        end else if (w_edit) begin
            w_idle_cnt = w_idle_inc;
            if (bus.inc_btn && (r_rep_st != REP_OFF)) begin
                if (w_rep_hit) begin
                    w_increase = 1'b1;
                    w_rep_st   = REP_RATE;
                    w_idle_cnt = '0;
                end else begin
                    w_rep_st  = r_rep_st;
                    w_rep_cnt = w_rep_inc;
                end
            end
        end
    end

    // State register; btn_d resets high so buttons held through reset
    // must be released before they count as a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode_d   <= 1'b1;
            r_set_d    <= 1'b1;
            r_inc_d    <= 1'b1;
            r_mode1    <= M1_TIME;
            r_mode2    <= 2'd0;
            r_increase <= 1'b0;
            r_set      <= 1'b0;
            r_rep_st   <= REP_OFF;
            r_rep_cnt  <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_mode_d   <= bus.mode_btn;
            r_set_d    <= bus.set_btn;
            r_inc_d    <= bus.inc_btn;
            r_mode1    <= w_mode1;
            r_mode2    <= w_mode2;
            r_increase <= w_increase;
            r_set      <= w_set;
            r_rep_st   <= w_rep_st;
            r_rep_cnt  <= w_rep_cnt;
            r_idle_cnt <= w_idle_cnt;
        end
    end

    assign bus.mode1    = r_mode1;
    assign bus.mode2    = r_mode2;
    assign bus.increase = r_increase;
    assign bus.set      = r_set;

endmodule

// File: tb/tb_mode_ctrl.sv
// Scoreboard bench for mode_ctrl with short repeat/idle parameters.
module tb_mode_ctrl;

    localparam int unsigned P_DELAY = 4;
    localparam int unsigned P_RATE  = 2;
    localparam int unsigned P_IDLE  = 8;

    localparam int M_TIME  = 0;
    localparam int M_DATE  = 1;
    localparam int M_TIMER = 2;
    localparam int M_ALARM = 3;

    logic clk = 1'b0;
    logic reset;

    mode_ctrl_if bus ();

    mode_ctrl #(
        .REPEAT_DELAY (P_DELAY),
        .REPEAT_RATE  (P_RATE),
        .IDLE_TIMEOUT (P_IDLE),
        .CNT_W        (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    m1;
        int    m2;
        int    inc;
        int    set;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock of stimulus; the expected outputs after the coming edge go
    // onto the scoreboard.
    task automatic cyc(input string tag, input logic m, input logic s, input logic i,
                       input int em1, input int em2, input int einc, input int eset);
        exp_t x;
        @(negedge clk);
        bus.mode_btn = m;
        bus.set_btn  = s;
        bus.inc_btn  = i;
        x.tag = tag; x.m1 = em1; x.m2 = em2; x.inc = einc; x.set = eset;
        q.push_back(x);
        @(posedge clk);
    endtask

    // Compare registered outputs just after each active edge.
    always begin
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check_eq({e.tag, ".mode1"},    32'(bus.mode1),    32'(e.m1));
            check_eq({e.tag, ".mode2"},    32'(bus.mode2),    32'(e.m2));
            check_eq({e.tag, ".increase"}, 32'(bus.increase), 32'(e.inc));
            check_eq({e.tag, ".set"},      32'(bus.set),      32'(e.set));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.mode_btn = 1'b0;
        bus.set_btn  = 1'b0;
        bus.inc_btn  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.mode1",    32'(bus.mode1),    0);
        check_eq("rst.mode2",    32'(bus.mode2),    0);
        check_eq("rst.increase", 32'(bus.increase), 0);
        check_eq("rst.set",      32'(bus.set),      0);
        @(negedge clk);
        reset = 1'b0;

        // Mode cycling, one cycle after each press.
        cyc("s1_settle", 0, 0, 0, M_TIME, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc("s1_mode", 1, 0, 0, k % 4, 0, 0, 0);
            cyc("s1_rel",  0, 0, 0, k % 4, 0, 0, 0);
        end

        // ALARM edit, hold inc 10 cycles: pulses at 1, 5, 7, 9.
        for (int k = 1; k <= 3; k++) begin
            cyc("s2_mode", 1, 0, 0, k, 0, 0, 0);
            cyc("s2_rel",  0, 0, 0, k, 0, 0, 0);
        end
        cyc("s2_set",     0, 1, 0, M_ALARM, 1, 0, 1);
        cyc("s2_set_rel", 0, 0, 0, M_ALARM, 1, 0, 0);
        for (int j = 0; j < 10; j++)
            cyc("s2_hold", 0, 0, 1, M_ALARM, 1, (j == 0 || j == 4 || j == 6 || j == 8) ? 1 : 0, 0);
        for (int j = 0; j < 3; j++)
            cyc("s2_release", 0, 0, 0, M_ALARM, 1, 0, 0);
        cyc("s2_exit",     1, 0, 0, M_TIME, 0, 0, 0);
        cyc("s2_exit_rel", 0, 0, 0, M_TIME, 0, 0, 0);

        // TIME, field B, then idle timeout on the 8th cycle.
        cyc("s3_set1", 0, 1, 0, M_TIME, 1, 0, 1);
        cyc("s3_rel",  0, 0, 0, M_TIME, 1, 0, 0);
        cyc("s3_set2", 0, 1, 0, M_TIME, 2, 0, 1);
        for (int i = 1; i <= 8; i++)
            cyc("s3_idle", 0, 0, 0, M_TIME, (i == 8) ? 0 : 2, 0, 0);
        cyc("s3_after", 0, 0, 0, M_TIME, 0, 0, 0);

        // mode beats inc in the same cycle; a press beats timeout expiry.
        cyc("s4_set",       0, 1, 0, M_TIME, 1, 0, 1);
        cyc("s4_rel",       0, 0, 0, M_TIME, 1, 0, 0);
        cyc("s4_prio",      1, 0, 1, M_DATE, 0, 0, 0);
        cyc("s4_prio_rel",  0, 0, 0, M_DATE, 0, 0, 0);
        cyc("s4_set_date",  0, 1, 0, M_DATE, 1, 0, 1);
        for (int i = 0; i < 7; i++)
            cyc("s4_idle", 0, 0, 0, M_DATE, 1, 0, 0);
        cyc("s4_tmo_press", 0, 1, 0, M_DATE, 2, 0, 1);
        cyc("s4_tmo_rel",   0, 0, 0, M_DATE, 2, 0, 0);
        cyc("s4_to_timer",  1, 0, 0, M_TIMER, 0, 0, 0);
        cyc("s4_timer_rel", 0, 0, 0, M_TIMER, 0, 0, 0);

        // TIMER: set toggles 0/1, inc does nothing, no idle timeout.
        cyc("s5_run",      0, 1, 0, M_TIMER, 1, 0, 1);
        cyc("s5_run_rel",  0, 0, 0, M_TIMER, 1, 0, 0);
        cyc("s5_inc",      0, 0, 1, M_TIMER, 1, 0, 0);
        cyc("s5_inc_rel",  0, 0, 0, M_TIMER, 1, 0, 0);
        cyc("s5_stop",     0, 1, 0, M_TIMER, 0, 0, 1);
        cyc("s5_stop_rel", 0, 0, 0, M_TIMER, 0, 0, 0);
        cyc("s5_run2",     0, 1, 0, M_TIMER, 1, 0, 1);
        for (int i = 0; i < 10; i++)
            cyc("s5_no_tmo", 0, 0, 0, M_TIMER, 1, 0, 0);
        cyc("s5_stop2",    0, 1, 0, M_TIMER, 0, 0, 1);
        cyc("s5_stop2_rel",0, 0, 0, M_TIMER, 0, 0, 0);

        // Reset mid-repeat while inc is held.
        cyc("s6_alarm",     1, 0, 0, M_ALARM, 0, 0, 0);
        cyc("s6_alarm_rel", 0, 0, 0, M_ALARM, 0, 0, 0);
        cyc("s6_set",       0, 1, 0, M_ALARM, 1, 0, 1);
        cyc("s6_set_rel",   0, 0, 0, M_ALARM, 1, 0, 0);
        for (int j = 0; j < 5; j++)
            cyc("s6_hold", 0, 0, 1, M_ALARM, 1, (j == 0 || j == 4) ? 1 : 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("s6_rst.mode1",    32'(bus.mode1),    0);
        check_eq("s6_rst.mode2",    32'(bus.mode2),    0);
        check_eq("s6_rst.increase", 32'(bus.increase), 0);
        check_eq("s6_rst.set",      32'(bus.set),      0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("s6_held", 0, 0, 1, M_TIME, 0, 0, 0);
        cyc("s6_edit_held", 0, 1, 1, M_TIME, 1, 0, 1);
        for (int i = 0; i < 6; i++)
            cyc("s6_no_repeat", 0, 0, 1, M_TIME, 1, 0, 0);
        cyc("s6_release", 0, 0, 0, M_TIME, 1, 0, 0);
        cyc("s6_repress", 0, 0, 1, M_TIME, 1, 1, 0);
        cyc("s6_final",   0, 0, 0, M_TIME, 1, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        check_eq("scoreboard_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
